// File: rtl/button_bounce_gen_pkg.sv
// Shared types and constants for the button stimulus blocks: FSM states,
// LFSR geometry and the bounce-count clamp.
package button_pkg;

  localparam int              LFSR_W       = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // A raw draw of zero still yields one glitch pair; large draws saturate.
  function automatic logic [3:0] clamp_k(input logic [3:0] raw, input logic [3:0] max_k);
    if (raw == 4'd0) begin
      return 4'd1;
    end else if (raw > max_k) begin
      return max_k;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/button_bounce_gen_lfsr.sv
// Free-running 16-bit Galois LFSR; reloads SEED on reset and never reaches
// zero from a non-zero seed.
module bounce_lfsr
  import button_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/button_bounce_gen.sv
// Turns a clean contact level into a bouncing one (2k+1 transitions, then a
// settle hold). Define BUTTON_BOUNCE_FIXED_EN for fixed k and gap timing.
module button_bounce_gen
  import button_pkg::*;
#(
  parameter int                MAX_BOUNCES   = 4,
  parameter int                MIN_GAP       = 4,
  parameter int                GAP_W         = 6,
  parameter int                SETTLE_CYCLES = 64,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clean,
  output logic   noisy,
  output logic   busy,
  output logic   settled,
  output state_e dbg_state
);

  localparam int GAP_CW = ((GAP_W > $clog2(MIN_GAP)) ? GAP_W : $clog2(MIN_GAP)) + 1;
  localparam int SET_CW = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [GAP_CW-1:0] MIN_GAP_C   = GAP_CW'(MIN_GAP);
  localparam logic [SET_CW-1:0] SETTLE_LOAD = SET_CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]        MAX_K       = 4'(MAX_BOUNCES);

  state_e            state_q, state_d;
  logic              noisy_d, busy_d, settled_d;
  logic [GAP_CW-1:0] gap_q, gap_d;
  logic [SET_CW-1:0] set_q, set_d;
  logic [4:0]        rem_q, rem_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic [3:0]        k_sel;
  logic [GAP_CW-1:0] gap_m1;
  logic              unused_lfsr;

  bounce_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only some LFSR bits feed the timing; fold the rest so nothing dangles.
  assign unused_lfsr = ^lfsr_q;

`ifdef BUTTON_BOUNCE_FIXED_EN
  assign k_sel  = MAX_K;
  assign gap_m1 = MIN_GAP_C - GAP_CW'(1);
`else
  assign k_sel  = clamp_k(lfsr_q[3:0], MAX_K);
  assign gap_m1 = MIN_GAP_C + {{(GAP_CW-GAP_W){1'b0}}, lfsr_q[GAP_W-1:0]} - GAP_CW'(1);
`endif

  always_comb begin
    state_d   = state_q;
    noisy_d   = noisy;
    gap_d     = gap_q;
    set_d     = set_q;
    rem_d     = rem_q;
    settled_d = 1'b0;
    if (!en) begin
      // Bypass: abort whatever is running and follow clean one cycle late.
      state_d = IDLE;
      noisy_d = clean;
      gap_d   = '0;
      set_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clean != noisy) begin
            noisy_d = clean;
            rem_d   = {k_sel, 1'b0};
            gap_d   = gap_m1;
            state_d = BOUNCE;
          end
        end
        BOUNCE: begin
          if (gap_q == '0) begin
            noisy_d = ~noisy;
            rem_d   = rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              set_d   = SETTLE_LOAD;
              state_d = SETTLE;
            end else begin
              gap_d = gap_m1;
            end
          end else begin
            gap_d = gap_q - GAP_CW'(1);
          end
        end
        SETTLE: begin
          if (set_q == '0) begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end else begin
            set_d = set_q - SET_CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      noisy   <= 1'b0;
      busy    <= 1'b0;
      settled <= 1'b0;
      gap_q   <= '0;
      set_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      noisy   <= noisy_d;
      busy    <= busy_d;
      settled <= settled_d;
      gap_q   <= gap_d;
      set_q   <= set_d;
      rem_q   <= rem_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: directed scenarios plus random clean/en/rst
// traffic, checked cycle by cycle against a schedule-based reference model.
module tb_button_bounce_gen;
  import button_pkg::*;

  localparam int          MAXB   = 3;
  localparam int          MING   = 2;
  localparam int          GW     = 3;
  localparam int          SETC   = 8;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic   clk = 1'b0;
  logic   rst, en, clean;
  logic   noisy, busy, settled;
  state_e dbg_state;

  always #5 clk = ~clk;

  button_bounce_gen #(
    .MAX_BOUNCES   (MAXB),
    .MIN_GAP       (MING),
    .GAP_W         (GW),
    .SETTLE_CYCLES (SETC),
    .SEED          (SEED_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clean     (clean),
    .noisy     (noisy),
    .busy      (busy),
    .settled   (settled),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic [15:0] m_lfsr = 16'h0;
  logic        m_noisy = 1'b0, m_busy = 1'b0, m_settled = 1'b0, m_active = 1'b0;
  int          tr_q[$];
  int          settle_at = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int kclamp(input int raw);
    if (raw == 0) return 1;
    if (raw > MAXB) return MAXB;
    return raw;
  endfunction

  // Precompute every transition time of a sequence starting now, walking a
  // private copy of the LFSR forward to each reload cycle.
  task automatic plan_sequence(input logic c);
    logic [15:0] l;
    int k, g, t_tr, t_l;
    l = m_lfsr;
`ifdef BUTTON_BOUNCE_FIXED_EN
    k = MAXB;
`else
    k = kclamp(int'(l[3:0]));
`endif
    m_noisy  = c;
    m_busy   = 1'b1;
    m_active = 1'b1;
    tr_q.delete();
    t_tr = cyc + 1;
    t_l  = cyc;
    for (int j = 0; j < 2 * k; j++) begin
`ifdef BUTTON_BOUNCE_FIXED_EN
      g = MING;
`else
      g = MING + int'(l[GW-1:0]);
`endif
      t_tr += g;
      tr_q.push_back(t_tr);
      while (t_l < t_tr - 1) begin
        l = lfsr_next(l);
        t_l++;
      end
    end
    settle_at = t_tr + SETC;
  endtask

  task automatic model_step(input logic r, input logic e, input logic c);
    if (r) begin
      m_noisy = 1'b0; m_busy = 1'b0; m_settled = 1'b0; m_active = 1'b0;
      tr_q.delete();
      m_lfsr = SEED_V;
      cyc++;
      return;
    end
    m_settled = 1'b0;
    if (!e) begin
      m_noisy = c; m_busy = 1'b0; m_active = 1'b0;
      tr_q.delete();
    end else if (m_active) begin
      if (tr_q.size() > 0 && tr_q[0] == cyc + 1) begin
        m_noisy = ~m_noisy;
        void'(tr_q.pop_front());
      end
      if (cyc + 1 == settle_at) begin
        m_active = 1'b0; m_busy = 1'b0; m_settled = 1'b1;
      end
    end else if (c != m_noisy) begin
      plan_sequence(c);
    end
    m_lfsr = lfsr_next(m_lfsr);
    cyc++;
  endtask

  // ---------------- sequence observer on the DUT outputs ----------------
  logic prev_busy = 1'b0, prev_noisy = 1'b0, obs_valid = 1'b0, start_lvl = 1'b0;
  int   obs_cnt = 0, last_tr = 0, n_seq_done = 0;

  task automatic observe(input logic r, input logic e);
    if (r || !e) begin
      obs_valid = 1'b0;
    end else if (busy && !prev_busy) begin
      obs_valid = 1'b1;
      obs_cnt   = (noisy != prev_noisy) ? 1 : 0;
      start_lvl = noisy;
      last_tr   = cyc;
    end else if (busy && obs_valid && noisy != prev_noisy) begin
      check("spacing_range",
            32'((cyc - last_tr >= MING) && (cyc - last_tr <= MING + (1 << GW) - 1)), 32'd1);
      obs_cnt++;
      last_tr = cyc;
    end else if (settled && obs_valid) begin
      check("trans_count_odd", 32'(obs_cnt % 2), 32'd1);
      check("trans_count_range", 32'((obs_cnt >= 3) && (obs_cnt <= 2 * MAXB + 1)), 32'd1);
      check("final_level", 32'(noisy), 32'(start_lvl));
      obs_valid = 1'b0;
      n_seq_done++;
    end
    prev_busy  = busy;
    prev_noisy = noisy;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic e, input logic c);
    rst = r; en = e; clean = c;
    @(posedge clk);
    model_step(r, e, c);
    #1;
    check("noisy", 32'(noisy), 32'(m_noisy));
    check("busy", 32'(busy), 32'(m_busy));
    check("settled", 32'(settled), 32'(m_settled));
    check("state_idle", 32'(dbg_state == IDLE), 32'(!m_busy));
    observe(r, e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, en, clean);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || m_busy) && n < budget) begin
      tick(1'b0, en, clean);
      n++;
    end
    check("idle_timeout", 32'(busy || m_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clean = 1'b0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("reset_lfsr", 32'(dut.u_lfsr.q), 32'(SEED_V));
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    run(2);

    // Press, then release: two complete sequences.
    tick(1'b0, 1'b1, 1'b1);
    check("first_transition", 32'(noisy), 32'd1);
    wait_idle(400);
    run(3);
    tick(1'b0, 1'b1, 1'b0);
    wait_idle(400);
    run(3);

    // Changes while busy are ignored; mismatch at the end restarts.
    tick(1'b0, 1'b1, 1'b1);
    run(4);
    tick(1'b0, 1'b1, 1'b0);
    wait_idle(400);
    run(2);
    wait_idle(400);
    run(3);

    // Drop en mid-sequence, toggle clean in bypass, then re-enable.
    tick(1'b0, 1'b1, 1'b1);
    run(5);
    tick(1'b0, 1'b0, 1'b1);
    check("bypass_busy", 32'(busy), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("bypass_follow", 32'(noisy), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    wait_idle(400);
    run(3);

    // Reset in the middle of a sequence.
    tick(1'b0, 1'b1, 1'b0);
    run(7);
    tick(1'b1, 1'b1, 1'b0);
    check("midrst_lfsr", 32'(dut.u_lfsr.q), 32'(SEED_V));
    check("midrst_noisy", 32'(noisy), 32'd0);
    run(3);

    // Random traffic with occasional bypass and reset cycles.
    for (int i = 0; i < 1000; i++) begin
      logic c;
      int   w;
      c = ($urandom_range(0, 3) != 0) ? ~clean : clean;
      w = $urandom_range(1, 60);
      for (int j = 0; j < w; j++) begin
        logic r, e;
        r = ($urandom_range(0, 999) == 0);
        e = ($urandom_range(0, 299) != 0);
        tick(r, e, (j == 0) ? c : clean);
      end
    end
    en = 1'b1;
    wait_idle(400);
    check("seq_observed", 32'(n_seq_done > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
